// File: rtl/iot_pkg.sv
// Shared definitions for the IOT pulse initiator: bus widths, IOP enable bit
// positions, slot-timer width and the sequencer state encoding.
package iot_pkg;

  localparam int DEV_W  = 6;
  localparam int WORD_W = 12;
  localparam int CNT_W  = 8;

  // Position of each IOP enable inside the latched instruction bits 9-11.
  localparam int IOP1_BIT = 2;
  localparam int IOP2_BIT = 1;
  localparam int IOP4_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    P1,
    G1,
    P2,
    G2,
    P4,
    G4
  } state_t;

endpackage

// File: rtl/iot_slot_timer.sv
// Slot timer: down-counter reloaded on every state entry, expire when it hits 0.
// Latency: a value L-1 loaded at one edge gives expire L edges later.
// No backpressure; load has priority over counting.
import iot_pkg::*;

module iot_slot_timer (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Reload on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/iot_pulse_gen.sv
// IOT initiator: drives device code/AC and issues the IOP1/IOP2/IOP4 pulse train.
// Latency: fixed SETTLE+3*(PULSE_W+GAP_W) cycles from accepted start to done.
// No backpressure: start is ignored while busy or during the done cycle.
import iot_pkg::*;

module iot_pulse_gen #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DEV_W-1:0]  mb_dev,
  input  logic [2:0]        mb_iop,
  input  logic [WORD_W-1:0] ac,
  input  logic              io_skip,
  input  logic              io_ac_clear,
  input  logic [WORD_W-1:0] io_in,
  output logic [DEV_W-1:0]  bmb,
  output logic [WORD_W-1:0] bac,
  output logic              iop1,
  output logic              iop2,
  output logic              iop4,
  output logic              busy,
  output logic              done,
  output logic              skip,
  output logic              ac_clear,
  output logic [WORD_W-1:0] in_data
);

  // Timer reload values: each state lasts exactly its parameter in cycles.
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LD_PULSE  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_W - 1);

  state_t           state;
  state_t           state_next;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             expire;
  logic             accept;
  logic             finish;
  logic [2:0]       iop_en;

  iot_slot_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and timer reload; the slot sequence is fixed whatever mb_iop holds.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle is still IDLE, so a start there must be refused.
        if (start && !done) begin
          state_next = iot_pkg::SETTLE;
          tmr_load   = 1'b1;
          tmr_val    = LD_SETTLE;
          accept     = 1'b1;
        end
      end
      iot_pkg::SETTLE: if (expire) begin state_next = P1; tmr_load = 1'b1; tmr_val = LD_PULSE; end
      P1:              if (expire) begin state_next = G1; tmr_load = 1'b1; tmr_val = LD_GAP;   end
      G1:              if (expire) begin state_next = P2; tmr_load = 1'b1; tmr_val = LD_PULSE; end
      P2:              if (expire) begin state_next = G2; tmr_load = 1'b1; tmr_val = LD_GAP;   end
      G2:              if (expire) begin state_next = P4; tmr_load = 1'b1; tmr_val = LD_PULSE; end
      P4:              if (expire) begin state_next = G4; tmr_load = 1'b1; tmr_val = LD_GAP;   end
      G4:              if (expire) begin state_next = IDLE; finish = 1'b1; end
      default:         state_next = IDLE;
    endcase
  end

  // Registered pulses decoded from the next state so they change on the slot edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iop1 <= 1'b0;
      iop2 <= 1'b0;
      iop4 <= 1'b0;
    end else begin
      iop1 <= (state_next == P1) && iop_en[IOP1_BIT];
      iop2 <= (state_next == P2) && iop_en[IOP2_BIT];
      iop4 <= (state_next == P4) && iop_en[IOP4_BIT];
    end
  end

  // Bus drive, enable latch and busy/done handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmb    <= '0;
      bac    <= '0;
      iop_en <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        bmb    <= mb_dev;
        bac    <= ac;
        iop_en <= mb_iop;
        busy   <= 1'b1;
      end else if (finish) begin
        bmb  <= '0;
        bac  <= '0;
        busy <= 1'b0;
      end
    end
  end

  // Device responses are accumulated only while a pulse is on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip     <= 1'b0;
      ac_clear <= 1'b0;
      in_data  <= '0;
    end else if (accept) begin
      skip     <= 1'b0;
      ac_clear <= 1'b0;
      in_data  <= '0;
    end else if (iop1 || iop2 || iop4) begin
      skip     <= skip | io_skip;
      ac_clear <= ac_clear | io_ac_clear;
      in_data  <= in_data | io_in;
    end
  end

endmodule

// File: tb/tb_iot_pulse_gen.sv
// Directed bench for iot_pulse_gen with default timing (S=P=G=2):
// edge Ek is k edges after start acceptance; outputs sampled 1ns after each edge.
module tb_iot_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  mb_dev;
  logic [2:0]  mb_iop;
  logic [11:0] ac;
  logic        io_skip;
  logic        io_ac_clear;
  logic [11:0] io_in;
  logic [5:0]  bmb;
  logic [11:0] bac;
  logic        iop1, iop2, iop4, busy, done, skip, ac_clear;
  logic [11:0] in_data;

  int checks = 0;
  int errors = 0;

  iot_pulse_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mb_dev      (mb_dev),
    .mb_iop      (mb_iop),
    .ac          (ac),
    .io_skip     (io_skip),
    .io_ac_clear (io_ac_clear),
    .io_in       (io_in),
    .bmb         (bmb),
    .bac         (bac),
    .iop1        (iop1),
    .iop2        (iop2),
    .iop4        (iop4),
    .busy        (busy),
    .done        (done),
    .skip        (skip),
    .ac_clear    (ac_clear),
    .in_data     (in_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let E0 take it, then scramble the request inputs.
  task automatic start_seq(input logic [5:0] dev, input logic [2:0] en, input logic [11:0] acv);
    @(negedge clk);
    mb_dev = dev;
    mb_iop = en;
    ac     = acv;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mb_dev = ~dev;
    mb_iop = ~en;
    ac     = ~acv;
    chk("e0_busy", 32'(busy), 32'd1);
    chk("e0_bmb", 32'(bmb), 32'(dev));
    chk("e0_bac", 32'(bac), 32'(acv));
    chk("e0_skip_clr", 32'(skip), 32'd0);
    chk("e0_acclr_clr", 32'(ac_clear), 32'd0);
    chk("e0_in_clr", 32'(in_data), 32'd0);
  endtask

  // Walk edges E1..E15; mode selects the bus stimulus driven between edges.
  task automatic walk(input logic [5:0] dev, input logic [11:0] acv, input logic [2:0] en,
                      input int mode, input logic xs, input logic xa, input logic [11:0] xin);
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("iop1_e%0d", e), 32'(iop1), 32'(en[2] && (e == 2 || e == 3)));
      chk($sformatf("iop2_e%0d", e), 32'(iop2), 32'(en[1] && (e == 6 || e == 7)));
      chk($sformatf("iop4_e%0d", e), 32'(iop4), 32'(en[0] && (e == 10 || e == 11)));
      chk($sformatf("busy_e%0d", e), 32'(busy), 32'(e < 14));
      chk($sformatf("done_e%0d", e), 32'(done), 32'(e == 14));
      chk($sformatf("bmb_e%0d", e), 32'(bmb), (e < 14) ? 32'(dev) : 32'd0);
      chk($sformatf("bac_e%0d", e), 32'(bac), (e < 14) ? 32'(acv) : 32'd0);
      if (e >= 14) begin
        chk($sformatf("skip_e%0d", e), 32'(skip), 32'(xs));
        chk($sformatf("acclr_e%0d", e), 32'(ac_clear), 32'(xa));
        chk($sformatf("in_e%0d", e), 32'(in_data), 32'(xin));
      end
      if (mode == 1) begin
        case (e)
          2:  io_skip = 1'b1;
          4:  begin io_skip = 1'b0; io_in = 12'o0001; end
          6:  begin io_in = 12'o0070; io_ac_clear = 1'b1; end
          8:  begin io_in = 12'o0000; io_ac_clear = 1'b0; end
          10: io_in = 12'o7000;
          12: io_in = 12'o0000;
          default: ;
        endcase
      end else if (mode == 2) begin
        case (e)
          4:  begin io_skip = 1'b1; start = 1'b1; end
          5:  start = 1'b0;
          6:  io_skip = 1'b0;
          14: start = 1'b1;
          15: start = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0; start = 1'b0; mb_dev = '0; mb_iop = '0; ac = '0;
    io_skip = 1'b0; io_ac_clear = 1'b0; io_in = '0;
    #12;
    chk("rst_iops", 32'({iop1, iop2, iop4}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_results", 32'({skip, ac_clear, in_data}), 32'd0);
    chk("rst_bus", 32'({bmb, bac}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All three pulses; skip in IOP1, data/AC clear in IOP2/IOP4, junk in a gap.
    start_seq(6'o34, 3'b111, 12'o1234);
    walk(6'o34, 12'o1234, 3'b111, 1, 1'b1, 1'b1, 12'o7070);
    tick();
    chk("hold_skip", 32'(skip), 32'd1);
    chk("hold_in", 32'(in_data), 32'o7070);
    chk("hold_acclr", 32'(ac_clear), 32'd1);

    // IOP2 only; skip only in G1; restart attempts at E5 and in the done cycle.
    start_seq(6'o12, 3'b010, 12'o0707);
    walk(6'o12, 12'o0707, 3'b010, 2, 1'b0, 1'b0, 12'o0000);
    tick();
    chk("done_cycle_start_ignored", 32'(busy), 32'd0);

    // No enables with active responses throughout: timing only, results stay 0.
    start_seq(6'o77, 3'b000, 12'o0001);
    io_skip = 1'b1; io_ac_clear = 1'b1; io_in = 12'o7777;
    walk(6'o77, 12'o0001, 3'b000, 0, 1'b0, 1'b0, 12'o0000);
    io_skip = 1'b0; io_ac_clear = 1'b0; io_in = '0;

    // Asynchronous reset in the middle of IOP2.
    start_seq(6'o05, 3'b111, 12'o7777);
    repeat (7) tick();
    chk("pre_rst_iop2", 32'(iop2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_iop2", 32'(iop2), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_bmb", 32'(bmb), 32'd0);
    chk("arst_bac", 32'(bac), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (iop1 || iop2 || iop4 || done || busy) bad = 1'b1;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
